// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
//   Board-wide shared definitions: the system clock rate, the default timing
//   constants for push-button conditioning, and the button conditioner state
//   type.
// -----------------------------------------------------------------------------
package board_pkg;

    // Board oscillator frequency.
    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    // 10 ms of stable input qualifies a press or release edge.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT   = CLK_FREQ_HZ / 100;

    // 1 s of holding after the press pulse qualifies a long press.
    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = CLK_FREQ_HZ;

    // Button conditioner FSM states.
    //   IDLE      : released, waiting for the synchronized input to go high
    //   PRESS_DEB : input high, counting stable samples before declaring a press
    //   HELD      : press qualified, waiting for the input to go low
    //   REL_DEB   : input low, counting stable samples before declaring release
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } btn_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Bundle of the button-side signals of a button conditioner.
//   master : the board/stimulus side; drives the raw button level and observes
//            the conditioned outputs.
//   slave  : the conditioner side; receives the raw level and drives the
//            debounced level and the event pulses.
//   Signals:
//     button     raw, asynchronous, bouncing push-button level
//     level      debounced button level
//     pressed    one-cycle pulse on a qualified press
//     released   one-cycle pulse on a qualified release
//     long_pulse one-cycle pulse when a press has been held long enough
// -----------------------------------------------------------------------------
interface button_conditioner_if;

    logic button;
    logic level;
    logic pressed;
    logic released;
    logic long_pulse;

    modport master (
        output button,
        input  level,
        input  pressed,
        input  released,
        input  long_pulse
    );

    modport slave (
        input  button,
        output level,
        output pressed,
        output released,
        output long_pulse
    );

endinterface

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Two-flop synchronizer for bringing asynchronous board inputs into the clk
//   domain. Both flops clear to 0 on an asynchronous active-high reset.
//   Ports:
//     clk  : destination clock
//     rst  : asynchronous, active-high reset
//     d    : asynchronous input
//     q    : synchronized output (second flop)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Synchronizes and debounces a raw push-button and produces a clean level
//   plus one-cycle PRESSED, RELEASED and LONG event pulses.
//   Parameters:
//     DEBOUNCE_CYCLES   : consecutive stable synchronized samples that qualify
//                         a press or release edge (>= 2)
//     LONG_PRESS_CYCLES : held cycles after the PRESSED pulse at which LONG
//                         fires (> DEBOUNCE_CYCLES)
//   Ports:
//     CLK      : board clock
//     RESET    : asynchronous, active-high reset
//     BUTTON   : raw, bouncing push-button level
//     LEVEL    : debounced level (1 while the press is qualified)
//     PRESSED  : one-cycle pulse on a qualified press
//     RELEASED : one-cycle pulse on a qualified release
//     LONG     : one-cycle pulse, at most once per press, on a long hold
// -----------------------------------------------------------------------------
module button_conditioner
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BUTTON,
    output logic LEVEL,
    output logic PRESSED,
    output logic RELEASED,
    output logic LONG
);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_conditioner: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
    end

    // Terminal counts, 32-bit unsigned like the counters they are compared to.
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);
    localparam logic [31:0] LONG_PRE  = 32'(LONG_PRESS_CYCLES - 2);

    logic sync;

    sync_ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (BUTTON),
        .q   (sync)
    );

    btn_state_e  state_d,      state_q;
    logic [31:0] deb_cnt_d,    deb_cnt_q;
    logic [31:0] long_cnt_d,   long_cnt_q;
    logic        long_fired_d, long_fired_q;
    logic        level_d,      level_q;
    logic        pressed_d,    pressed_q;
    logic        released_d,   released_q;
    logic        long_d,       long_q;

    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        long_cnt_d   = long_cnt_q;
        long_fired_d = long_fired_q;
        pressed_d    = 1'b0;
        released_d   = 1'b0;
        long_d       = 1'b0;

        // Long-press timing runs for the whole logical press, including
        // release-debounce intervals, and parks at its terminal count.
        if ((state_q == HELD || state_q == REL_DEB) && long_cnt_q < LONG_LAST) begin
            long_cnt_d = long_cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d   = PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end

            PRESS_DEB: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = HELD;
                    pressed_d    = 1'b1;
                    long_cnt_d   = '0;
                    long_fired_d = 1'b0;
                end else if (deb_cnt_q < DEB_LAST) begin
                    deb_cnt_d = deb_cnt_q + 32'd1;
                end
            end

            HELD: begin
                if (!sync) begin
                    state_d   = REL_DEB;
                    deb_cnt_d = '0;
                end
            end

            REL_DEB: begin
                // A bounce back high resumes HELD with long timing untouched.
                if (sync) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                end else if (deb_cnt_q < DEB_LAST) begin
                    deb_cnt_d = deb_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // LONG fires on the step into the terminal count. A release completing
        // on that same edge ends the press first, keeping the pulses exclusive.
        if ((state_q == HELD || state_q == REL_DEB) && long_cnt_q == LONG_PRE &&
            !long_fired_q && !released_d) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
        end

        level_d = (state_d == HELD) || (state_d == REL_DEB);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            deb_cnt_q    <= '0;
            long_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            long_cnt_q   <= long_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
            long_q       <= long_d;
        end
    end

    assign LEVEL    = level_q;
    assign PRESSED  = pressed_q;
    assign RELEASED = released_q;
    assign LONG     = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Drives a button waveform (directed scenarios then random segments and
//   random resets) and checks the conditioner against a level/run-length
//   model of the debounce rules. Expected events are queued as stimulus is
//   issued; a monitor pops and compares them as the DUT pulses.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic CLK;
    logic RESET;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUTTON   (bif.button),
        .LEVEL    (bif.level),
        .PRESSED  (bif.pressed),
        .RELEASED (bif.released),
        .LONG     (bif.long_pulse)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int tick = 0;
    always @(posedge CLK) tick <= tick + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard and model state
    ev_t exp_q[$];
    bit  dly_q[$];
    bit  level_exp[int];
    bit  m_level;
    int  m_run;
    int  m_press_at;
    bit  m_long_armed;

    // Observed-event trackers for directed checks
    int n_press = 0, n_rel = 0, n_long = 0;
    int last_press = -1, last_rel = -1, last_long = -1;

    function automatic string kname(input int k);
        case (k)
            K_PRESS: return "PRESSED";
            K_REL:   return "RELEASED";
            default: return "LONG";
        endcase
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The FSM decides at edge E on the button level that was set up before
    // edge E-2; right after reset it sees two zeros first.
    function automatic void model_clear();
        dly_q.delete();
        dly_q.push_back(1'b0);
        dly_q.push_back(1'b0);
        m_level      = 1'b0;
        m_run        = 0;
        m_press_at   = 0;
        m_long_armed = 1'b0;
    endfunction

    // A qualified edge needs D+1 consecutive samples opposite to the current
    // level, all taken after the last level change. LONG follows the press by
    // L-1 edges if the press is still standing then.
    function automatic void model_step(input bit v, input int e);
        bit  s;
        ev_t ev;
        dly_q.push_back(v);
        s = dly_q.pop_front();
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_run   = 0;
            m_level = !m_level;
            ev.at   = e;
            if (m_level) begin
                ev.kind      = K_PRESS;
                m_press_at   = e;
                m_long_armed = 1'b1;
            end else begin
                ev.kind      = K_REL;
                m_long_armed = 1'b0;
            end
            exp_q.push_back(ev);
        end
        if (m_level && m_long_armed && e == m_press_at + L - 1) begin
            ev.kind      = K_LONG;
            ev.at        = e;
            m_long_armed = 1'b0;
            exp_q.push_back(ev);
        end
        level_exp[e] = m_level;
    endfunction

    // Drive one button value for the coming edge; returns that edge number.
    task automatic step(input bit v, output int at);
        @(negedge CLK);
        #1;
        bif.button = v;
        at = tick + 1;
        model_step(v, at);
    endtask

    task automatic steps(input bit v, input int n, output int first_at);
        int a;
        for (int i = 0; i < n; i++) begin
            step(v, a);
            if (i == 0) first_at = a;
        end
    endtask

    task automatic release_reset(input bit v, output int at);
        @(negedge CLK);
        #1;
        RESET      = 1'b0;
        bif.button = v;
        model_clear();
        at = tick + 1;
        model_step(v, at);
    endtask

    // Asserts reset between clock edges and checks the outputs clear before
    // the next edge, holds it, then releases with the button at level v.
    task automatic do_reset(input int hold, input bit v, output int at);
        @(negedge CLK);
        #1;
        bif.button = v;
        #1;
        RESET = 1'b1;
        #1;
        check_eq("async_reset_level",    int'(bif.level),      0);
        check_eq("async_reset_pressed",  int'(bif.pressed),    0);
        check_eq("async_reset_released", int'(bif.released),   0);
        check_eq("async_reset_long",     int'(bif.long_pulse), 0);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].at > tick)
            exp_q.delete(exp_q.size() - 1);
        repeat (hold) @(posedge CLK);
        release_reset(v, at);
    endtask

    task automatic monitor_sample();
        int  np;
        int  kind;
        ev_t ev;
        np = int'(bif.pressed) + int'(bif.released) + int'(bif.long_pulse);
        if (RESET) begin
            checks++;
            if (bif.level !== 1'b0 || np != 0) begin
                errors++;
                $display("FAIL reset_outputs tick=%0d level=%b pulses=%0d required level=0 pulses=0",
                         tick, bif.level, np);
            end
            return;
        end
        if (level_exp.exists(tick)) begin
            checks++;
            if (bif.level !== level_exp[tick]) begin
                errors++;
                $display("FAIL level tick=%0d actual=%b expected=%b", tick, bif.level, level_exp[tick]);
            end
        end
        if (np > 0) begin
            checks++;
            if (np > 1) begin
                errors++;
                $display("FAIL exclusive tick=%0d pulses=%0d required=1", tick, np);
            end
            kind = bif.pressed ? K_PRESS : (bif.released ? K_REL : K_LONG);
            case (kind)
                K_PRESS: begin n_press++; last_press = tick; end
                K_REL:   begin n_rel++;   last_rel   = tick; end
                default: begin n_long++;  last_long  = tick; end
            endcase
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_%s tick=%0d expected no event", kname(kind), tick);
            end else begin
                ev = exp_q.pop_front();
                if (ev.kind != kind || ev.at != tick) begin
                    errors++;
                    $display("FAIL event actual=%s@%0d expected=%s@%0d",
                             kname(kind), tick, kname(ev.kind), ev.at);
                end
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at <= tick) begin
                ev = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_%s tick=%0d expected at %0d", kname(ev.kind), tick, ev.at);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            monitor_sample();
        end
    end

    initial begin : stimulus
        int t0, t1, tmp, bp, br, bl;
        RESET      = 1'b1;
        bif.button = 1'b0;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        check_eq("reset_level", int'(bif.level), 0);
        release_reset(1'b0, tmp);
        steps(1'b0, 5, tmp);

        // Clean press held 10 cycles, then release
        bp = n_press; br = n_rel; bl = n_long;
        steps(1'b1, 10, t0);
        steps(1'b0, 12, tmp);
        check_eq("clean_press_latency", last_press - t0, 6);
        check_eq("clean_release_latency", last_rel - t0, 16);
        check_eq("clean_press_count", n_press - bp, 1);
        check_eq("clean_no_long", n_long - bl, 0);

        // Bounce: high 2, low 1, five times
        bp = n_press;
        for (int i = 0; i < 5; i++) begin
            steps(1'b1, 2, tmp);
            steps(1'b0, 1, tmp);
        end
        steps(1'b0, 10, tmp);
        check_eq("bounce_no_press", n_press - bp, 0);

        // Long hold of 40 cycles
        bp = n_press; bl = n_long;
        steps(1'b1, 40, t0);
        check_eq("hold_press_latency", last_press - t0, 6);
        check_eq("hold_long_after_press", last_long - last_press, 19);
        check_eq("hold_long_once", n_long - bl, 1);
        steps(1'b0, 12, tmp);
        check_eq("hold_release_latency", last_rel - t0, 46);
        check_eq("hold_long_once_after_release", n_long - bl, 1);

        // Two-cycle low glitch while held
        br = n_rel; bl = n_long;
        steps(1'b1, 12, t0);
        steps(1'b0, 2, tmp);
        steps(1'b1, 20, tmp);
        check_eq("glitch_no_release", n_rel - br, 0);
        check_eq("glitch_level_high", int'(bif.level), 1);
        check_eq("glitch_long_timing", last_long - t0, 25);
        steps(1'b0, 12, tmp);
        check_eq("glitch_final_release", n_rel - br, 1);

        // Reset mid-HELD with the button kept high
        steps(1'b1, 10, t0);
        check_eq("prereset_press_latency", last_press - t0, 6);
        br = n_rel;
        do_reset(3, 1'b1, t1);
        steps(1'b1, 10, tmp);
        check_eq("postreset_press_latency", last_press - t1, 6);
        check_eq("reset_no_release", n_rel - br, 0);
        steps(1'b0, 12, tmp);

        // Random segments with occasional resets
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 24) == 0)
                do_reset(int'($urandom_range(2, 4)), bit'($urandom_range(0, 1)), tmp);
            else if ($urandom_range(0, 1) == 0)
                steps(bit'($urandom_range(0, 1)), int'($urandom_range(1, 6)), tmp);
            else
                steps(bit'($urandom_range(0, 1)), int'($urandom_range(1, 30)), tmp);
        end

        steps(1'b0, 30, tmp);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the number of consecutive stable synchronized samples that qualify an edge (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 100_000_000, giving the held cycles after the PRESSED pulse at which LONG fires (1 s at 100 MHz).
REQ-003 The block SHALL have port CLK, input, 1 bit: board clock, single clock domain.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port BUTTON, input, 1 bit: raw, asynchronous, bouncing push-button level.
REQ-006 The block SHALL have port LEVEL, output, 1 bit: debounced button level.
REQ-007 The block SHALL have port PRESSED, output, 1 bit: one-cycle pulse on a qualified press.
REQ-008 The block SHALL have port RELEASED, output, 1 bit: one-cycle pulse on a qualified release.
REQ-009 The block SHALL have port LONG, output, 1 bit: one-cycle pulse when a press reaches LONG_PRESS_CYCLES.

Function
REQ-010 BUTTON SHALL pass through a 2-flop synchronizer, both flops resetting to 0; downstream logic uses only the second flop output (SYNC).
REQ-011 The FSM SHALL have states IDLE, PRESS_DEB, HELD and REL_DEB.
REQ-012 IDLE: SYNC=1 SHALL give PRESS_DEB with debounce counter cleared to 0; SYNC=0 SHALL keep IDLE.
REQ-013 PRESS_DEB: SYNC=0 SHALL give IDLE with no output pulse; SYNC=1 with counter below DEBOUNCE_CYCLES-1 SHALL increment the counter; SYNC=1 with counter equal to DEBOUNCE_CYCLES-1 SHALL give HELD, register PRESSED=1 for exactly one cycle, and clear the long counter.
REQ-014 HELD: the long counter SHALL increment every cycle and saturate at LONG_PRESS_CYCLES-1. On the cycle it reaches LONG_PRESS_CYCLES-1, LONG SHALL pulse once; at most one LONG SHALL occur per press.
REQ-015 HELD: SYNC=0 SHALL give REL_DEB with the debounce counter cleared.
REQ-016 REL_DEB: SYNC=1 SHALL return to HELD with the long counter and LONG-fired flag preserved (a bounce does not restart long timing).
REQ-017 REL_DEB: SYNC=0 with counter equal to DEBOUNCE_CYCLES-1 SHALL give IDLE and register RELEASED=1 for one cycle; otherwise the counter SHALL increment.
REQ-018 The long counter SHALL continue counting and saturating while in REL_DEB.
REQ-019 LEVEL SHALL be registered: 1 in HELD and REL_DEB, 0 in IDLE and PRESS_DEB.
REQ-020 Latency: with BUTTON rising and stable before edge 0, SYNC SHALL be 1 after edge 1, the state SHALL be PRESS_DEB after edge 2, and PRESSED and LEVEL SHALL be 1 after edge DEBOUNCE_CYCLES+2. Release latency SHALL be symmetric for RELEASED and LEVEL falling.
REQ-021 PRESSED, RELEASED and LONG SHALL be mutually exclusive in any cycle.
REQ-022 All counters SHALL be 32 bits unsigned and SHALL never wrap.
REQ-023 Elaboration SHALL fail unless DEBOUNCE_CYCLES>=2 and LONG_PRESS_CYCLES>DEBOUNCE_CYCLES.

Reset
REQ-024 RESET=1 SHALL immediately force IDLE, clear both synchronizer flops, both counters and the LONG-fired flag, and drive LEVEL, PRESSED, RELEASED and LONG to 0, with no clock required.
REQ-025 A button held through reset deassertion SHALL be re-qualified from IDLE and SHALL produce PRESSED DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
REQ-026 Reset asserted mid-press SHALL NOT produce RELEASED.

Structure
REQ-027 The state enum typedef and the default cycle constants SHALL live in shared package board_pkg, alongside the existing clock-rate constant.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module named sync_ff, with async active-high reset, reusable for other board inputs.
REQ-029 The block SHALL use a single always_ff block for state and counters plus an always_comb block for next state.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-030 Clean press at edge 0 held 10 cycles, then release -> PRESSED after edge 6 only, LEVEL=1 from edge 6; RELEASED 6 edges after the release; no LONG.
REQ-031 Bounce: BUTTON high 2 cycles, low 1 cycle, repeated 5 times -> PRESSED never asserts, LEVEL stays 0.
REQ-032 Hold 40 cycles -> PRESSED at edge 6; LONG exactly once, 19 edges after PRESSED; no further LONG before release.
REQ-033 While HELD, a 2-cycle low glitch -> no RELEASED; LEVEL stays 1; LONG timing unchanged.
REQ-034 RESET asserted mid-HELD with BUTTON kept high -> outputs 0 immediately and no RELEASED; after deassertion, PRESSED again at post-reset edge 6.
REQ-035 Reset asserted between clock edges -> outputs go to 0 asynchronously, checked before the next CLK edge.
